// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry/MRET sequencer driving the CSR file write port
module trap_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  input  logic        irq_ok,
  input  logic [31:0] irq_pc,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        tmr_irq,
  input  logic [31:0] mstatus,
  input  logic [31:0] mie,
  input  logic [31:0] mip,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic [11:0] pipe_csr_addr,
  input  logic [31:0] pipe_csr_wdata,
  input  logic        pipe_csr_write,
  input  logic [31:0] pipe_csr_set,
  input  logic        pipe_csr_set_valid,
  input  logic [31:0] pipe_csr_clear,
  input  logic        pipe_csr_clear_valid,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        csr_write,
  output logic [31:0] csr_set,
  output logic        csr_set_valid,
  output logic [31:0] csr_clear,
  output logic        csr_clear_valid,
  output logic        busy,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [2:0] {IDLE, T_EPC, T_CAUSE, T_STATUS, T_REDIR, R_STATUS, R_REDIR} state_t;
  state_t state, state_n;
  logic [31:0] epc, cause, pend;
  logic is_irq, take_irq, accept;
  logic [3:0] irq_code;
  assign pend = (mip | {20'b0, ext_irq, 3'b0, tmr_irq, 3'b0, sw_irq, 3'b0}) & mie;
  assign take_irq = irq_ok & mstatus[3] & (pend[11] | pend[3] | pend[7]);
  assign irq_code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
  assign accept = state == IDLE && (exc_valid || mret_valid || take_irq);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      epc    <= '0;
      cause  <= '0;
      is_irq <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && exc_valid) begin
        epc    <= exc_pc;
        cause  <= {28'b0, exc_cause};
        is_irq <= 1'b0;
      end else if (state == IDLE && !mret_valid && take_irq) begin
        epc    <= irq_pc;
        cause  <= {1'b1, 27'b0, irq_code};
        is_irq <= 1'b1;
      end
    end
  end
  always_comb begin
    state_n         = IDLE;
    csr_addr        = '0;
    csr_wdata       = '0;
    csr_write       = 1'b0;
    csr_set         = '0;
    csr_set_valid   = 1'b0;
    csr_clear       = '0;
    csr_clear_valid = 1'b0;
    busy            = state != IDLE;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = RESET_PC;
    case (state)
      IDLE: begin
        // Outputs held at zero while reset is asserted, since state alone cannot express that
        if (rst && accept) begin
          flush   = 1'b1;
          state_n = (!exc_valid && mret_valid) ? R_STATUS : T_EPC;
        end else if (rst) begin
          csr_addr        = pipe_csr_addr;
          csr_wdata       = pipe_csr_wdata;
          csr_write       = pipe_csr_write;
          csr_set         = pipe_csr_set;
          csr_set_valid   = pipe_csr_set_valid;
          csr_clear       = pipe_csr_clear;
          csr_clear_valid = pipe_csr_clear_valid;
        end
      end
      T_EPC: begin
        csr_write = 1'b1;
        csr_addr  = 12'h341;
        csr_wdata = epc;
        state_n   = T_CAUSE;
      end
      T_CAUSE: begin
        csr_write = 1'b1;
        csr_addr  = 12'h342;
        csr_wdata = cause;
        state_n   = T_STATUS;
      end
      T_STATUS: begin
        csr_write = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = (mstatus & ~32'h88) | {24'b0, mstatus[3], 7'b0} | 32'h1800;
        state_n   = T_REDIR;
      end
      T_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = {mtvec[31:2], 2'b00} +
                         ((mtvec[1:0] == 2'd1 && is_irq) ? {26'b0, cause[3:0], 2'b00} : 32'd0);
      end
      R_STATUS: begin
        csr_write = 1'b1;
        csr_addr  = 12'h300;
        csr_wdata = (mstatus & ~32'h8) | {28'b0, mstatus[7], 3'b0} | 32'h1880;
        state_n   = R_REDIR;
      end
      R_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mepc;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed vectors for trap_controller with hand-computed expectations
module tb_trap_controller;
  logic clk = 1'b0, rst;
  logic exc_valid, mret_valid, irq_ok, ext_irq, sw_irq, tmr_irq;
  logic [3:0] exc_cause;
  logic [31:0] exc_pc, irq_pc, mstatus, mie, mip, mtvec, mepc;
  logic [11:0] pipe_csr_addr, csr_addr;
  logic [31:0] pipe_csr_wdata, pipe_csr_set, pipe_csr_clear, csr_wdata, csr_set, csr_clear, redirect_pc;
  logic pipe_csr_write, pipe_csr_set_valid, pipe_csr_clear_valid;
  logic csr_write, csr_set_valid, csr_clear_valid, busy, flush, redirect_valid;
  int errors = 0, checks = 0;

  trap_controller dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_valid(mret_valid), .irq_ok(irq_ok), .irq_pc(irq_pc), .ext_irq(ext_irq),
    .sw_irq(sw_irq), .tmr_irq(tmr_irq), .mstatus(mstatus), .mie(mie), .mip(mip),
    .mtvec(mtvec), .mepc(mepc), .pipe_csr_addr(pipe_csr_addr), .pipe_csr_wdata(pipe_csr_wdata),
    .pipe_csr_write(pipe_csr_write), .pipe_csr_set(pipe_csr_set),
    .pipe_csr_set_valid(pipe_csr_set_valid), .pipe_csr_clear(pipe_csr_clear),
    .pipe_csr_clear_valid(pipe_csr_clear_valid), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_write(csr_write), .csr_set(csr_set), .csr_set_valid(csr_set_valid),
    .csr_clear(csr_clear), .csr_clear_valid(csr_clear_valid), .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seq(input string tag, input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".wr"}, 32'(csr_write), 32'd1);
    chk({tag, ".addr"}, 32'(csr_addr), 32'(a));
    chk({tag, ".data"}, csr_wdata, d);
    cyc();
  endtask

  task automatic redir(input string tag, input logic [31:0] pc);
    @(negedge clk);
    chk({tag, ".rv"}, 32'(redirect_valid), 32'd1);
    chk({tag, ".pc"}, redirect_pc, pc);
    chk({tag, ".wr"}, 32'(csr_write), 32'd0);
    cyc();
  endtask

  initial begin
    {exc_valid, mret_valid, irq_ok, ext_irq, sw_irq, tmr_irq} = '0;
    exc_cause = '0; exc_pc = '0; irq_pc = '0; mstatus = '0; mie = '0; mip = '0; mtvec = '0; mepc = '0;
    pipe_csr_addr = 12'h304; pipe_csr_wdata = 32'hA5; pipe_csr_write = 1'b1;
    pipe_csr_set = 32'h11; pipe_csr_set_valid = 1'b1; pipe_csr_clear = 32'h22; pipe_csr_clear_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.wr", 32'(csr_write), 32'd0);
    chk("rst.addr", 32'(csr_addr), 32'd0);
    chk("rst.setv", 32'(csr_set_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.pc", redirect_pc, 32'd0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("pass.wr", 32'(csr_write), 32'd1);
    chk("pass.addr", 32'(csr_addr), 32'h304);
    chk("pass.data", csr_wdata, 32'hA5);
    chk("pass.set", csr_set, 32'h11);
    chk("pass.setv", 32'(csr_set_valid), 32'd1);
    chk("pass.clr", csr_clear, 32'h22);
    cyc();
    // exception and MRET together; pipe write stays held throughout
    exc_valid = 1'b1; mret_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100;
    mtvec = 32'h2001; mstatus = 32'h8; mepc = 32'h999;
    @(negedge clk);
    chk("exc.flush", 32'(flush), 32'd1);
    chk("exc.acc_wr", 32'(csr_write), 32'd0);
    chk("exc.acc_setv", 32'(csr_set_valid), 32'd0);
    cyc();
    exc_valid = 1'b0; mret_valid = 1'b0;
    write_seq("exc.epc", 12'h341, 32'h100);
    write_seq("exc.cause", 12'h342, 32'h2);
    write_seq("exc.status", 12'h300, 32'h1880);
    redir("exc.redir", 32'h2000);
    @(negedge clk);
    chk("exc.idle_busy", 32'(busy), 32'd0);
    chk("exc.idle_wr", 32'(csr_write), 32'd1);
    chk("exc.idle_addr", 32'(csr_addr), 32'h304);
    chk("exc.idle_rv", 32'(redirect_valid), 32'd0);
    cyc();
    // vectored external interrupt, beats timer
    ext_irq = 1'b1; tmr_irq = 1'b1; mie = 32'h880; mstatus = 32'h8; irq_ok = 1'b1;
    irq_pc = 32'h44; mtvec = 32'h1001;
    @(negedge clk);
    chk("irq.flush", 32'(flush), 32'd1);
    cyc();
    irq_ok = 1'b0;
    write_seq("irq.epc", 12'h341, 32'h44);
    write_seq("irq.cause", 12'h342, 32'h8000000B);
    write_seq("irq.status", 12'h300, 32'h1880);
    redir("irq.redir", 32'h102C);
    // masked by irq_ok=0, then by MIE=0
    @(negedge clk);
    chk("noirq_ok.flush", 32'(flush), 32'd0);
    chk("noirq_ok.wr", 32'(csr_write), 32'd1);
    cyc();
    irq_ok = 1'b1; mstatus = 32'h0;
    @(negedge clk);
    chk("nomie.flush", 32'(flush), 32'd0);
    chk("nomie.busy", 32'(busy), 32'd0);
    chk("nomie.addr", 32'(csr_addr), 32'h304);
    cyc();
    @(negedge clk);
    chk("nomie.still_idle", 32'(busy), 32'd0);
    cyc();
    irq_ok = 1'b0; ext_irq = 1'b0; tmr_irq = 1'b0;
    // MRET
    mret_valid = 1'b1; mstatus = 32'h1880; mepc = 32'h200;
    @(negedge clk);
    chk("mret.flush", 32'(flush), 32'd1);
    cyc();
    mret_valid = 1'b0;
    write_seq("mret.status", 12'h300, 32'h1888);
    redir("mret.redir", 32'h200);
    @(negedge clk);
    chk("mret.idle", 32'(busy), 32'd0);
    cyc();
    // reset in the middle of T_CAUSE
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300;
    cyc();
    exc_valid = 1'b0;
    write_seq("rstmid.epc", 12'h341, 32'h300);
    @(negedge clk);
    chk("rstmid.cause_addr", 32'(csr_addr), 32'h342);
    #1 rst = 1'b0;
    #1;
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.wr", 32'(csr_write), 32'd0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.after_busy", 32'(busy), 32'd0);
    chk("rstmid.after_addr", 32'(csr_addr), 32'h304);
    chk("rstmid.after_wr", 32'(csr_write), 32'd1);
    cyc();
    @(negedge clk);
    chk("rstmid.no_resume", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer sitting directly upstream of the CSR file, on its write port.
- Accepts synchronous exceptions, interrupt lines and MRET from the pipeline, and detects enabled pending interrupts using the CSR file's mstatus/mie/mip/mtvec/mepc outputs.
- Sequences trap entry/exit as single-port CSR writes, then redirects fetch.
- When idle, passes the pipeline's CSR-instruction requests through unchanged.

Parameters:
- RESET_PC, 32'h0000_0000, reported on redirect_pc while idle (informational only).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- exc_valid  input  1  exception from instruction at exc_pc
- exc_cause  input  4  exception code (mcause[3:0])
- exc_pc  input  32  PC of faulting instruction
- mret_valid  input  1  MRET retiring
- irq_ok  input  1  pipeline at an instruction boundary; interrupt may be taken
- irq_pc  input  32  PC of next instruction (interrupt mepc)
- ext_irq  input  1  level interrupt, external (cause 11)
- sw_irq  input  1  level interrupt, software (cause 3)
- tmr_irq  input  1  level interrupt, timer (cause 7)
- mstatus, mie, mip, mtvec, mepc  input  32 each  live CSR file outputs
- pipe_csr_addr  input  12  pipeline CSR request: address
- pipe_csr_wdata  input  32  pipeline CSR request: write data
- pipe_csr_write  input  1  pipeline CSR request: write strobe
- pipe_csr_set  input  32  pipeline CSR request: set mask
- pipe_csr_set_valid  input  1  pipeline CSR request: set strobe
- pipe_csr_clear  input  32  pipeline CSR request: clear mask
- pipe_csr_clear_valid  input  1  pipeline CSR request: clear strobe
- csr_addr  output  12  to CSR file: address
- csr_wdata  output  32  to CSR file: write data
- csr_write  output  1  to CSR file: write strobe
- csr_set  output  32  to CSR file: set mask
- csr_set_valid  output  1  to CSR file: set strobe
- csr_clear  output  32  to CSR file: clear mask
- csr_clear_valid  output  1  to CSR file: clear strobe
- busy  output  1  sequence in progress; pipeline must stall
- flush  output  1  one-cycle pulse on trap/MRET acceptance
- redirect_valid  output  1  one-cycle fetch redirect
- redirect_pc  output  32  fetch target

Behaviour:
- States: IDLE, T_EPC, T_CAUSE, T_STATUS, T_REDIR, R_STATUS, R_REDIR. Register state plus latched epc[31:0], cause[31:0], is_irq.
- Reset (rst=0, any state): state=IDLE, epc=0, cause=0, is_irq=0.
  - All strobes/busy/flush/redirect_valid=0; csr_addr=0; csr_wdata=0; csr_set=0; csr_clear=0; redirect_pc=RESET_PC.
  - Reset mid-sequence abandons it; no further CSR writes are issued.
- Pending interrupts: pend = (mip | ext_irq<<11 | tmr_irq<<7 | sw_irq<<3) & mie.
  - take_irq = irq_ok & mstatus[3] & (pend[11]|pend[3]|pend[7]).
  - Priority: 11 > 3 > 7.
- Acceptance (IDLE only, priority exc_valid > mret_valid > take_irq):
  - exc: epc=exc_pc; cause={28'b0,exc_cause}; is_irq=0 -> T_EPC.
  - irq: epc=irq_pc; cause={1'b1,27'b0,code}; is_irq=1 -> T_EPC.
  - mret: -> R_STATUS.
  - Acceptance cycle: flush=1 and pipe CSR request suppressed (all csr strobes 0).
- Requests while busy are ignored; the pipeline holds them stable.
- Pass-through: in IDLE with no acceptance, all csr_* outputs equal the corresponding pipe_csr_* inputs combinationally.
- Non-IDLE states: csr_set_valid=csr_clear_valid=0; csr_write=1 only in T_EPC/T_CAUSE/T_STATUS/R_STATUS.
  - T_EPC: addr 12'h341, wdata=epc.
  - T_CAUSE: addr 12'h342, wdata=cause.
  - T_STATUS: addr 12'h300, wdata=(mstatus & ~32'h88) | mstatus[3]<<7 | 32'h1800 (MPIE<-MIE, MIE<-0, MPP<-11).
  - T_REDIR: redirect_valid=1, then -> IDLE.
    - Base = {mtvec[31:2],2'b00}.
    - redirect_pc = base + (mtvec[1:0]==1 && is_irq ? cause[3:0]*4 : 0).
    - mtvec[1:0] of 2 or 3 is treated as direct mode.
  - R_STATUS: addr 12'h300, wdata=(mstatus & ~32'h8) | mstatus[7]<<3 | 32'h1880 (MIE<-MPIE, MPIE<-1, MPP stays 11).
  - R_REDIR: redirect_valid=1, redirect_pc=mepc, then -> IDLE.
- busy=1 in every state except IDLE. Trap latency: acceptance to redirect = 4 cycles. MRET latency = 2 cycles.
- Fixed sequencing: each non-IDLE state lasts exactly one cycle.
- redirect_pc=RESET_PC whenever redirect_valid=0.
- An interrupt is re-evaluated in the IDLE cycle immediately after a redirect. Back-to-back traps are legal.

Test Plan:
- Reset mid-T_CAUSE -> next cycles IDLE, csr_write=0, busy=0; a subsequent pipe_csr_write to 0x304 passes through unchanged.
- exc_valid, cause 2, exc_pc=0x100, mtvec=0x2001, mstatus=0x8 ->
  - accept cycle: flush=1.
  - +1: write 0x341=0x100.
  - +2: write 0x342=0x2.
  - +3: write 0x300=0x1880.
  - +4: redirect_pc=0x2000 (direct, exception in vectored mode).
- ext_irq=1, tmr_irq=1, mie=0x880, mstatus=0x8, irq_ok=1, irq_pc=0x44, mtvec=0x1001 ->
  - mcause written 0x8000000B.
  - redirect_pc=0x102C.
- Same interrupt with mstatus[3]=0 or irq_ok=0 -> no acceptance; pipe CSR requests pass through.
- mret_valid, mstatus=0x1880, mepc=0x200 ->
  - +1: write 0x300=0x1888.
  - +2: redirect_pc=0x200.
- exc_valid and mret_valid in the same IDLE cycle -> exception sequence only.
  - A pipe_csr_write held during busy does not reach csr_write until IDLE.
